mole_rand_seq: RTL and testbench
================================

Name: mole_rand_seq

Overview:
Parametrised pseudo-random mole-pattern generator for the Wack-A-Mole game, replacing the fixed 16-bit / 8-hole / 1 Hz generator.
- A free-running counter seeds a lock-up-safe Fibonacci LFSR.
- The LFSR's output bit is shifted into an N_CH×DEPTH delay line; one tap per hole drives the mole enables.
- The shift rate comes from an internal programmable tick divider, so the game FSM can change speed per level without an external slow clock.

Parameters:
LFSR_W, 16, LFSR and seed-counter width (≥4)
TAPS, 16'h002D, feedback mask; feedback = XOR of mem bits where TAPS=1 (default = bits 0,2,3,5)
N_CH, 8, number of holes (ctrl width)
DEPTH, 60, delay-line stages per hole
DIV_W, 26, width of tick_period

Ports:
CLOCK_50  in  1  system clock
Rreset_n  in  1  asynchronous active-low reset
Rload_lfsr  in  1  capture seed-counter value into LFSR this cycle
Rshift  in  1  advance LFSR one step this cycle
Rspeed  in  1  0: delay line shifts every cycle; 1: shifts on divider tick
Rclear  in  1  synchronous clear of delay line and divider
tick_period  in  DIV_W  cycles per tick when Rspeed=1 (0 treated as 1)
ctrl  out  N_CH  mole enables; ctrl[i] = line[(i+1)*DEPTH-1]
step  out  1  registered; high for one cycle while ctrl shows freshly shifted values
lfsr_q  out  LFSR_W  current LFSR state (debug/score hashing)

Behaviour:
- Async reset (Rreset_n=0) takes effect immediately, no clock needed: seed counter=0, LFSR=1, divider=0, delay line=0, ctrl=0, step=0.
- Seed counter:
  - +1 every cycle, wraps at 2^LFSR_W-1 → 0.
  - Unaffected by Rclear.
- LFSR (priority Rload_lfsr > Rshift > hold):
  - Load: mem <= seed count; a count of 0 loads 1 (all-zero lock-up is never possible).
  - Shift: mem <= {fb, mem[LFSR_W-1:1]}, fb = ^(mem & TAPS).
  - Random bit r = mem[0], sampled before any same-cycle LFSR update.
- Divider / shift enable:
  - Rspeed=0: shift_en=1 every cycle; divider held at 0.
  - Rspeed=1: divider counts 0..P-1, with P = max(tick_period,1). shift_en=1 in the cycle divider==P-1 (or divider≥P-1 after a mid-count period decrease); divider then returns to 0.
  - P=1: shift_en every cycle.
  - Rspeed toggled 0→1: counting starts at 0; first shift_en occurs P cycles later.
- Delay line (N_CH*DEPTH bits):
  - Priority: Rclear > shift_en.
  - On shift_en: line <= {r, line} >> 1, i.e. r enters the MSB and older bits move toward the LSB.
  - Rclear=1: line=0 and divider=0; no shift that cycle; step=0 next cycle.
- ctrl is registered line taps, never combinational from inputs. The newest bit appears on ctrl[N_CH-1] one cycle after the shift_en edge.
- step is a register: step <= shift_en & ~Rclear. It aligns with the first cycle ctrl reflects the shift.
- Rload_lfsr and Rshift are independent of shift_en. The line may shift with a stale r if the LFSR is not advanced; this is the game FSM's choice.
- Width rules:
  - All counters are unsigned and wrap modulo 2^width.
  - tick_period is sampled every cycle; no latching.

Decomposition:
- Shared package mole_pkg: default TAPS constant, LFSR_W/N_CH/DEPTH defaults, ctrl index helper function.
- One sub-module, mole_tick_div: DIV_W divider producing the shift_en pulse from Rspeed, tick_period and Rclear.
- LFSR, seed counter and delay line stay in the top block.

Test Plan:
- Reset: run 100 cycles with random stimulus, drop Rreset_n between clock edges → ctrl=0, step=0, lfsr_q=16'h0001 immediately, before the next edge.
- Zero seed: release reset, assert Rload_lfsr on the first edge (count=0) → lfsr_q=16'h0001. Load at count=16'h1234 → lfsr_q=16'h1234.
- LFSR step: lfsr_q=16'h0001, Rshift for 3 cycles → 16'h8000, 16'h4000, 16'h2000. Rload_lfsr and Rshift together → load wins.
- Divider: Rspeed=1, tick_period=4 → step every 4th cycle. Change tick_period to 2 at divider=3 → shift_en next cycle, then every 2. tick_period=0 → step every cycle.
- Propagation: defaults, Rspeed=0, inject a single r=1 followed by zeros → ctrl[7] high after shift 1, ctrl[6] after shift 61, ctrl[0] after shift 421; exactly one ctrl bit high at a time.
- Clear: Rclear coincident with shift_en while line is non-zero → line=0 next cycle, step=0, divider restarts; LFSR and seed counter keep running.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared defaults and helpers for the Wack-A-Mole pseudo-random mole pattern generator.
package mole_pkg;

  localparam int unsigned    LFSR_W_DEF = 16;
  localparam logic [15:0]    TAPS_DEF   = 16'h002D;
  localparam int unsigned    N_CH_DEF   = 8;
  localparam int unsigned    DEPTH_DEF  = 60;
  localparam int unsigned    DIV_W_DEF  = 26;

  typedef enum logic {
    SPEED_FAST = 1'b0,
    SPEED_TICK = 1'b1
  } speed_e;

  // Delay-line bit that feeds mole enable 'ch' (last stage of that hole's segment).
  function automatic int unsigned ctrl_tap(input int unsigned ch, input int unsigned depth);
    return (ch + 1) * depth - 1;
  endfunction

endpackage

// File: rtl/mole_tick_div.sv
// Programmable tick divider: produces the delay-line shift enable for the mole generator.
module mole_tick_div
  import mole_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             speed,
  input  logic             clear,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  speed_e           mode;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] p_eff;
  logic             hit;

  assign mode = speed_e'(speed);

  // '>=' rather than '==' so a mid-count period decrease fires at once instead of wrapping.
  always_comb begin
    p_eff = (period == '0) ? DIV_W'(1) : period;
    hit   = (div >= (p_eff - DIV_W'(1)));
    tick  = (mode == SPEED_FAST) ? 1'b1 : hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (clear || (mode == SPEED_FAST) || hit) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/mole_rand_seq.sv
// Pseudo-random mole pattern generator: seed counter, lock-up-safe LFSR and per-hole delay line.
module mole_rand_seq
  import mole_pkg::*;
#(
  parameter int unsigned        LFSR_W = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'(TAPS_DEF),
  parameter int unsigned        N_CH   = N_CH_DEF,
  parameter int unsigned        DEPTH  = DEPTH_DEF,
  parameter int unsigned        DIV_W  = DIV_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              Rreset_n,
  input  logic              Rload_lfsr,
  input  logic              Rshift,
  input  logic              Rspeed,
  input  logic              Rclear,
  input  logic [DIV_W-1:0]  tick_period,
  output logic [N_CH-1:0]   ctrl,
  output logic              step,
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam int unsigned LINE_W = N_CH * DEPTH;

  logic [LFSR_W-1:0] seed_cnt;
  logic [LFSR_W-1:0] mem;
  logic [LINE_W-1:0] line;
  logic              shift_en;
  logic              r;
  logic              fb;

  assign r      = mem[0];
  assign fb     = ^(mem & TAPS);
  assign lfsr_q = mem;

  always_ff @(posedge CLOCK_50 or negedge Rreset_n) begin
    if (!Rreset_n) begin
      seed_cnt <= '0;
    end else begin
      seed_cnt <= seed_cnt + LFSR_W'(1);
    end
  end

  // A zero seed is replaced by 1 so the LFSR can never enter the all-zero state.
  always_ff @(posedge CLOCK_50 or negedge Rreset_n) begin
    if (!Rreset_n) begin
      mem <= LFSR_W'(1);
    end else if (Rload_lfsr) begin
      mem <= (seed_cnt == '0) ? LFSR_W'(1) : seed_cnt;
    end else if (Rshift) begin
      mem <= {fb, mem[LFSR_W-1:1]};
    end
  end

  mole_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk    (CLOCK_50),
    .rst_n  (Rreset_n),
    .speed  (Rspeed),
    .clear  (Rclear),
    .period (tick_period),
    .tick   (shift_en)
  );

  always_ff @(posedge CLOCK_50 or negedge Rreset_n) begin
    if (!Rreset_n) begin
      line <= '0;
      step <= 1'b0;
    end else begin
      if (Rclear) begin
        line <= '0;
      end else if (shift_en) begin
        line <= {r, line[LINE_W-1:1]};
      end
      step <= shift_en & ~Rclear;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_tap
    assign ctrl[g] = line[ctrl_tap(g, DEPTH)];
  end

endmodule

// File: tb/tb_mole_rand_seq.sv
// Directed self-checking bench for mole_rand_seq at default parameters.
module tb_mole_rand_seq;

  localparam int unsigned DIV_W = 26;

  logic             CLOCK_50 = 1'b0;
  logic             Rreset_n = 1'b0;
  logic             Rload_lfsr = 1'b0;
  logic             Rshift = 1'b0;
  logic             Rspeed = 1'b0;
  logic             Rclear = 1'b0;
  logic [DIV_W-1:0] tick_period = '0;
  logic [7:0]       ctrl;
  logic             step;
  logic [15:0]      lfsr_q;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] cnt_m;

  mole_rand_seq dut (
    .CLOCK_50    (CLOCK_50),
    .Rreset_n    (Rreset_n),
    .Rload_lfsr  (Rload_lfsr),
    .Rshift      (Rshift),
    .Rspeed      (Rspeed),
    .Rclear      (Rclear),
    .tick_period (tick_period),
    .ctrl        (ctrl),
    .step        (step),
    .lfsr_q      (lfsr_q)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference seed counter: edges since reset release, modulo 2^16.
  always @(posedge CLOCK_50 or negedge Rreset_n) begin
    if (!Rreset_n) cnt_m <= '0;
    else           cnt_m <= cnt_m + 16'd1;
  end

  task automatic do_reset();
    Rreset_n = 1'b0;
    Rload_lfsr = 1'b0; Rshift = 1'b0; Rspeed = 1'b0; Rclear = 1'b0; tick_period = '0;
    @(posedge CLOCK_50); #1;
    Rreset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (100) begin
      @(posedge CLOCK_50); #1;
      Rload_lfsr  = 1'($urandom_range(0, 1));
      Rshift      = 1'($urandom_range(0, 1));
      Rspeed      = 1'($urandom_range(0, 1));
      Rclear      = ($urandom_range(0, 7) == 0);
      tick_period = DIV_W'($urandom_range(0, 5));
    end
    #2;
    Rreset_n = 1'b0;
    #1;
    n_cmp++; if (ctrl !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl got %h want %h", ctrl, 8'h00); end
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL reset_step got %b want %b", step, 1'b0); end
    n_cmp++; if (lfsr_q !== 16'h0001) begin n_bad++; $display("FAIL reset_lfsr got %h want %h", lfsr_q, 16'h0001); end
  endtask

  task automatic test_zero_seed();
    do_reset();
    Rload_lfsr = 1'b1;
    @(posedge CLOCK_50); #1;
    n_cmp++; if (lfsr_q !== 16'h0001) begin n_bad++; $display("FAIL zero_seed got %h want %h", lfsr_q, 16'h0001); end
    Rload_lfsr = 1'b0;
    repeat (16'h1233) @(posedge CLOCK_50);
    #1;
    Rload_lfsr = 1'b1;
    @(posedge CLOCK_50); #1;
    n_cmp++; if (lfsr_q !== 16'h1234) begin n_bad++; $display("FAIL seed_1234 got %h want %h", lfsr_q, 16'h1234); end
    Rload_lfsr = 1'b0;
  endtask

  task automatic test_lfsr_step();
    logic [15:0] exp;
    do_reset();
    Rshift = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge CLOCK_50); #1;
      case (k)
        1:  exp = 16'h8000;
        2:  exp = 16'h4000;
        3:  exp = 16'h2000;
        12: exp = 16'h8010;
        14: exp = 16'hA004;
        default: exp = lfsr_q;
      endcase
      if (k <= 3 || k == 12 || k == 14) begin
        n_cmp++;
        if (lfsr_q !== exp) begin n_bad++; $display("FAIL lfsr_step%0d got %h want %h", k, lfsr_q, exp); end
      end
    end
    Rload_lfsr = 1'b1;
    exp = (cnt_m == 16'h0000) ? 16'h0001 : cnt_m;
    @(posedge CLOCK_50); #1;
    n_cmp++; if (lfsr_q !== exp) begin n_bad++; $display("FAIL load_over_shift got %h want %h", lfsr_q, exp); end
    Rload_lfsr = 1'b0; Rshift = 1'b0;
  endtask

  task automatic test_divider();
    logic [14:0] exp_bits;
    exp_bits = 15'b101010010001000;
    do_reset();
    @(posedge CLOCK_50); #1;
    Rspeed = 1'b1; tick_period = DIV_W'(4);
    for (int k = 1; k <= 15; k++) begin
      @(posedge CLOCK_50); #1;
      n_cmp++;
      if (step !== exp_bits[k-1]) begin n_bad++; $display("FAIL div_s%0d got %b want %b", k, step, exp_bits[k-1]); end
      if (k == 10) tick_period = DIV_W'(2);
    end
    tick_period = '0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLOCK_50); #1;
      n_cmp++;
      if (step !== 1'b1) begin n_bad++; $display("FAIL div_p0_s%0d got %b want %b", k, step, 1'b1); end
    end
  endtask

  task automatic test_propagation();
    logic [7:0] exp;
    do_reset();
    Rclear = 1'b1;
    @(posedge CLOCK_50); #1;
    Rclear = 1'b0; Rshift = 1'b1;
    for (int k = 1; k <= 430; k++) begin
      @(posedge CLOCK_50); #1;
      Rshift = 1'b0;
      if (((k - 1) % 60 == 0) && ((k - 1) / 60 < 8)) exp = 8'h80 >> ((k - 1) / 60);
      else exp = 8'h00;
      n_cmp++;
      if (ctrl !== exp) begin n_bad++; $display("FAIL prop_shift%0d got %h want %h", k, ctrl, exp); end
    end
  endtask

  task automatic test_clear();
    logic [15:0] exp;
    do_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_cmp++; if (ctrl !== 8'h80) begin n_bad++; $display("FAIL clr_fill got %h want %h", ctrl, 8'h80); end
    Rspeed = 1'b1; tick_period = DIV_W'(3);
    repeat (2) @(posedge CLOCK_50);
    #1;
    Rclear = 1'b1; Rshift = 1'b1;
    @(posedge CLOCK_50); #1;
    Rclear = 1'b0; Rshift = 1'b0;
    n_cmp++; if (ctrl !== 8'h00) begin n_bad++; $display("FAIL clr_ctrl got %h want %h", ctrl, 8'h00); end
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL clr_step got %b want %b", step, 1'b0); end
    n_cmp++; if (lfsr_q !== 16'h8000) begin n_bad++; $display("FAIL clr_lfsr got %h want %h", lfsr_q, 16'h8000); end
    for (int k = 4; k <= 6; k++) begin
      @(posedge CLOCK_50); #1;
      n_cmp++;
      if (step !== (k == 6)) begin n_bad++; $display("FAIL clr_div_s%0d got %b want %b", k, step, (k == 6)); end
    end
    Rload_lfsr = 1'b1;
    exp = (cnt_m == 16'h0000) ? 16'h0001 : cnt_m;
    @(posedge CLOCK_50); #1;
    Rload_lfsr = 1'b0;
    n_cmp++; if (lfsr_q !== exp) begin n_bad++; $display("FAIL clr_seed got %h want %h", lfsr_q, exp); end
  endtask

  initial begin
    #1;
    test_reset();
    test_zero_seed();
    test_lfsr_step();
    test_divider();
    test_propagation();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
